// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data main-memory arbiter.
// Optional feature macro: MEM_ARB_RR_EN (round-robin tie-break).
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 28;   // block address, word address [31:4]
  localparam int DATA_W_DEF = 128;  // one block, 4 x 32-bit words

  // Arbiter state encoding
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_I = 2'b01,
    GRANT_D = 2'b10,
    RELEASE = 2'b11
  } arb_state_t;

  // Grant-select values, also used as the grant-history encoding
  localparam logic SEL_I = 1'b0;
  localparam logic SEL_D = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational tie-break between the I-cache and D-cache requests.
// Optional feature macro: MEM_ARB_RR_EN. Defined: a tie goes to the side
// that was not granted last. Undefined: the D side wins every tie.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic hist,     // side granted most recently (SEL_I / SEL_D)
  output logic grant_d
);

  logic tie_to_d;

`ifdef MEM_ARB_RR_EN
  assign tie_to_d = (hist == SEL_I);
`else
  logic unused_hist;
  assign unused_hist = hist;
  assign tie_to_d    = 1'b1;
`endif

  // D wins when it is the sole requester or when it wins the tie
  assign grant_d = d_req & (~i_req | tie_to_d);

endmodule

// File: rtl/mem_arbiter.sv
// Serialises 128-bit block transactions from the I-cache (read-only) and
// the D-cache (read/write) onto the single main memory, using the same
// level-held request / BUSYWAIT handshake as the caches. State changes on
// the falling clock edge; RESET is asynchronous and active-high.
// Optional feature macro: MEM_ARB_RR_EN (round-robin on simultaneous
// requests; when undefined the D side has fixed priority).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  // I-cache side
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDR,
  output logic [DATA_W-1:0] I_READDATA,
  output logic              I_BUSYWAIT,
  // D-cache side
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [DATA_W-1:0] D_WRITEDATA,
  output logic [DATA_W-1:0] D_READDATA,
  output logic              D_BUSYWAIT,
  // Memory side
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT
);

  arb_state_t state, next_state;
  logic       d_req;
  logic       grant_d;
  logic       hist;
  logic       d_is_write;  // operation captured when the D side is granted

  assign d_req = D_READ | D_WRITE;

  // Read data is shared: each cache only consumes it while it is granted
  assign I_READDATA = MEM_READDATA;
  assign D_READDATA = MEM_READDATA;

  mem_arb_pick u_pick (
    .i_req   (I_READ),
    .d_req   (d_req),
    .hist    (hist),
    .grant_d (grant_d)
  );

  // State register, advanced on the falling edge
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(negedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  // Capture write-vs-read at grant time so the strobe cannot change if the
  // requester drops its lines mid-transaction; write wins if both are high
  always_ff @(negedge CLK or posedge RESET) begin
    if (RESET)                                         d_is_write <= 1'b0;
    else if (state == IDLE && next_state == GRANT_D)   d_is_write <= D_WRITE;
  end

`ifdef MEM_ARB_RR_EN
  // Grant history: remembers which side was granted last
  always_ff @(negedge CLK or posedge RESET) begin
    if (RESET) begin
      hist <= SEL_I;
    end else if (state == IDLE) begin
      if (next_state == GRANT_D)      hist <= SEL_D;
      else if (next_state == GRANT_I) hist <= SEL_I;
    end
  end
`else
  assign hist = SEL_I;
`endif

  // Next-state and state-decoded outputs
  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state    = state;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDR      = '0;
    MEM_WRITEDATA = '0;
    I_BUSYWAIT    = I_READ;
    D_BUSYWAIT    = d_req;

    case (state)
      IDLE: begin
        if (I_READ || d_req) next_state = grant_d ? GRANT_D : GRANT_I;
      end

      GRANT_I: begin
        MEM_READ   = 1'b1;
        MEM_ADDR   = I_ADDR;
        I_BUSYWAIT = MEM_BUSYWAIT;
        if (!MEM_BUSYWAIT) next_state = RELEASE;
      end

      GRANT_D: begin
        if (d_is_write) begin
          MEM_WRITE     = 1'b1;
          MEM_WRITEDATA = D_WRITEDATA;
        end else begin
          MEM_READ      = 1'b1;
        end
        MEM_ADDR   = D_ADDR;
        D_BUSYWAIT = MEM_BUSYWAIT;
        if (!MEM_BUSYWAIT) next_state = RELEASE;
      end

      RELEASE: begin
        // One strobe-free cycle so the finished requester can drop its request
        next_state = IDLE;
      end

      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a simple stalling memory model.
// Tie-break expectations follow MEM_ARB_RR_EN when it is defined.
module tb_mem_arbiter;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam int STALL  = 5;
  // Memory model counts posedges under a strobe; busy is sampled high on
  // STALL-1 consecutive posedges after the grant.
  localparam int BUSY_SAMPLES = STALL - 1;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              I_READ = 1'b0;
  logic [ADDR_W-1:0] I_ADDR = '0;
  logic [DATA_W-1:0] I_READDATA;
  logic              I_BUSYWAIT;
  logic              D_READ = 1'b0;
  logic              D_WRITE = 1'b0;
  logic [ADDR_W-1:0] D_ADDR = '0;
  logic [DATA_W-1:0] D_WRITEDATA = '0;
  logic [DATA_W-1:0] D_READDATA;
  logic              D_BUSYWAIT;
  logic              MEM_READ;
  logic              MEM_WRITE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_WRITEDATA;
  logic [DATA_W-1:0] MEM_READDATA = '0;
  logic              MEM_BUSYWAIT;

  int total = 0;
  int bad   = 0;
  int mem_cnt = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .I_READ        (I_READ),
    .I_ADDR        (I_ADDR),
    .I_READDATA    (I_READDATA),
    .I_BUSYWAIT    (I_BUSYWAIT),
    .D_READ        (D_READ),
    .D_WRITE       (D_WRITE),
    .D_ADDR        (D_ADDR),
    .D_WRITEDATA   (D_WRITEDATA),
    .D_READDATA    (D_READDATA),
    .D_BUSYWAIT    (D_BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDR      (MEM_ADDR),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  // Memory model: busy while strobed until STALL posedges have elapsed
  always @(posedge CLK) begin
    if (MEM_READ || MEM_WRITE) begin
      if (mem_cnt != STALL) mem_cnt <= mem_cnt + 1;
    end else begin
      mem_cnt <= 0;
    end
  end
  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mem_cnt != STALL);

  // Advance one cycle; sample point is 1 time unit after the posedge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Count samples with the chosen BUSYWAIT high, stopping at the first free one
  task automatic wait_free(input bit d_side, output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if ((d_side ? D_BUSYWAIT : I_BUSYWAIT) == 1'b0) break;
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    I_READ = 1'b1;
    D_WRITEDATA = {4{32'hDEAD_BEEF}};
    step();
    step();
    total++; if (MEM_READ !== 1'b0) begin bad++; $display("FAIL reset.mem_read got=%b exp=0", MEM_READ); end
    total++; if (MEM_WRITE !== 1'b0) begin bad++; $display("FAIL reset.mem_write got=%b exp=0", MEM_WRITE); end
    total++; if (MEM_ADDR !== 28'h0) begin bad++; $display("FAIL reset.mem_addr got=%h exp=0", MEM_ADDR); end
    total++; if (MEM_WRITEDATA !== 128'h0) begin bad++; $display("FAIL reset.mem_writedata got=%h exp=0", MEM_WRITEDATA); end
    total++; if (I_BUSYWAIT !== 1'b1) begin bad++; $display("FAIL reset.i_busywait_req got=%b exp=1", I_BUSYWAIT); end
    total++; if (D_BUSYWAIT !== 1'b0) begin bad++; $display("FAIL reset.d_busywait_idle got=%b exp=0", D_BUSYWAIT); end
    I_READ = 1'b0;
    D_WRITE = 1'b1;
    #1;
    total++; if (D_BUSYWAIT !== 1'b1) begin bad++; $display("FAIL reset.d_busywait_req got=%b exp=1", D_BUSYWAIT); end
    total++; if (I_BUSYWAIT !== 1'b0) begin bad++; $display("FAIL reset.i_busywait_idle got=%b exp=0", I_BUSYWAIT); end
    D_WRITE = 1'b0;
    RESET = 1'b0;
    step();
    step();
  endtask

  task automatic test_i_only();
    int n;
    MEM_READDATA = {32{4'hA}};
    I_ADDR = 28'h0000010;
    I_READ = 1'b1;
    step();
    total++; if (MEM_READ !== 1'b1) begin bad++; $display("FAIL i_only.mem_read got=%b exp=1", MEM_READ); end
    total++; if (MEM_WRITE !== 1'b0) begin bad++; $display("FAIL i_only.mem_write got=%b exp=0", MEM_WRITE); end
    total++; if (MEM_ADDR !== 28'h0000010) begin bad++; $display("FAIL i_only.mem_addr got=%h exp=0000010", MEM_ADDR); end
    total++; if (I_BUSYWAIT !== 1'b1) begin bad++; $display("FAIL i_only.i_busywait got=%b exp=1", I_BUSYWAIT); end
    total++; if (D_BUSYWAIT !== 1'b0) begin bad++; $display("FAIL i_only.d_busywait got=%b exp=0", D_BUSYWAIT); end
    wait_free(1'b0, n);
    total++; if (n !== BUSY_SAMPLES) begin bad++; $display("FAIL i_only.busy_cycles got=%0d exp=%0d", n, BUSY_SAMPLES); end
    total++; if (MEM_READ !== 1'b1) begin bad++; $display("FAIL i_only.read_at_done got=%b exp=1", MEM_READ); end
    total++; if (I_READDATA !== {32{4'hA}}) begin bad++; $display("FAIL i_only.readdata got=%h exp=%h", I_READDATA, {32{4'hA}}); end
    I_READ = 1'b0;
    step();
    total++; if (MEM_READ !== 1'b0) begin bad++; $display("FAIL i_only.release_read got=%b exp=0", MEM_READ); end
    step();
    total++; if (MEM_READ !== 1'b0 || MEM_ADDR !== 28'h0) begin bad++; $display("FAIL i_only.idle got read=%b addr=%h exp read=0 addr=0", MEM_READ, MEM_ADDR); end
  endtask

  task automatic test_d_write();
    int n;
    D_ADDR = 28'h0000020;
    D_WRITEDATA = 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978;
    D_WRITE = 1'b1;
    step();
    total++; if (MEM_WRITE !== 1'b1) begin bad++; $display("FAIL d_write.mem_write got=%b exp=1", MEM_WRITE); end
    total++; if (MEM_READ !== 1'b0) begin bad++; $display("FAIL d_write.mem_read got=%b exp=0", MEM_READ); end
    total++; if (MEM_ADDR !== 28'h0000020) begin bad++; $display("FAIL d_write.mem_addr got=%h exp=0000020", MEM_ADDR); end
    total++; if (MEM_WRITEDATA !== 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978) begin bad++; $display("FAIL d_write.writedata got=%h", MEM_WRITEDATA); end
    total++; if (D_BUSYWAIT !== 1'b1) begin bad++; $display("FAIL d_write.d_busywait got=%b exp=1", D_BUSYWAIT); end
    total++; if (I_BUSYWAIT !== 1'b0) begin bad++; $display("FAIL d_write.i_busywait got=%b exp=0", I_BUSYWAIT); end
    wait_free(1'b1, n);
    total++; if (n !== BUSY_SAMPLES) begin bad++; $display("FAIL d_write.busy_cycles got=%0d exp=%0d", n, BUSY_SAMPLES); end
    total++; if (MEM_WRITE !== 1'b1) begin bad++; $display("FAIL d_write.write_at_done got=%b exp=1", MEM_WRITE); end
    D_WRITE = 1'b0;
    step();
    total++; if (MEM_WRITE !== 1'b0) begin bad++; $display("FAIL d_write.release_write got=%b exp=0", MEM_WRITE); end
    step();
  endtask

  task automatic test_tie_serve();
    int n;
    RESET = 1'b1;
    #2;
    RESET = 1'b0;
    step();
    MEM_READDATA = {32{4'hD}};
    I_ADDR = 28'h0000030;
    D_ADDR = 28'h0000040;
    I_READ = 1'b1;
    D_READ = 1'b1;
    step();
    total++; if (MEM_READ !== 1'b1 || MEM_ADDR !== 28'h0000040) begin bad++; $display("FAIL tie_serve.first_grant got read=%b addr=%h exp read=1 addr=0000040", MEM_READ, MEM_ADDR); end
    n = 0;
    for (int k = 0; k < 40 && D_BUSYWAIT; k++) begin
      total++; if (I_BUSYWAIT !== 1'b1) begin bad++; $display("FAIL tie_serve.i_stalled got=%b exp=1", I_BUSYWAIT); end
      n++;
      step();
    end
    total++; if (n !== BUSY_SAMPLES) begin bad++; $display("FAIL tie_serve.d_busy_cycles got=%0d exp=%0d", n, BUSY_SAMPLES); end
    total++; if (D_READDATA !== {32{4'hD}}) begin bad++; $display("FAIL tie_serve.d_readdata got=%h", D_READDATA); end
    D_READ = 1'b0;
    step();
    total++; if (MEM_READ !== 1'b0 || I_BUSYWAIT !== 1'b1) begin bad++; $display("FAIL tie_serve.release got read=%b ibw=%b exp read=0 ibw=1", MEM_READ, I_BUSYWAIT); end
    step();
    total++; if (MEM_READ !== 1'b0 || I_BUSYWAIT !== 1'b1) begin bad++; $display("FAIL tie_serve.idle got read=%b ibw=%b exp read=0 ibw=1", MEM_READ, I_BUSYWAIT); end
    step();
    total++; if (MEM_READ !== 1'b1 || MEM_ADDR !== 28'h0000030) begin bad++; $display("FAIL tie_serve.second_grant got read=%b addr=%h exp read=1 addr=0000030", MEM_READ, MEM_ADDR); end
    wait_free(1'b0, n);
    total++; if (n !== BUSY_SAMPLES) begin bad++; $display("FAIL tie_serve.i_busy_cycles got=%0d exp=%0d", n, BUSY_SAMPLES); end
    I_READ = 1'b0;
    step();
    step();
  endtask

  // Three ties in a row; the loser withdraws after the winner completes
  task automatic test_tie_sequence();
    int n;
    logic exp_d;
    logic [ADDR_W-1:0] exp_addr;
    I_ADDR = 28'h0000031;
    D_ADDR = 28'h0000041;
    for (int t = 0; t < 3; t++) begin
`ifdef MEM_ARB_RR_EN
      exp_d = (t != 1);
`else
      exp_d = 1'b1;
`endif
      exp_addr = exp_d ? 28'h0000041 : 28'h0000031;
      I_READ = 1'b1;
      D_READ = 1'b1;
      step();
      total++; if (MEM_ADDR !== exp_addr || MEM_READ !== 1'b1) begin bad++; $display("FAIL tie_seq.grant%0d got read=%b addr=%h exp read=1 addr=%h", t, MEM_READ, MEM_ADDR, exp_addr); end
      total++; if ((exp_d ? I_BUSYWAIT : D_BUSYWAIT) !== 1'b1) begin bad++; $display("FAIL tie_seq.loser_stall%0d got ibw=%b dbw=%b", t, I_BUSYWAIT, D_BUSYWAIT); end
      wait_free(exp_d, n);
      total++; if (n !== BUSY_SAMPLES) begin bad++; $display("FAIL tie_seq.busy%0d got=%0d exp=%0d", t, n, BUSY_SAMPLES); end
      I_READ = 1'b0;
      D_READ = 1'b0;
      step();
      step();
      total++; if (MEM_READ !== 1'b0) begin bad++; $display("FAIL tie_seq.idle%0d got read=%b exp=0", t, MEM_READ); end
    end
  endtask

  task automatic test_illegal();
    int n;
    D_ADDR = 28'h0000050;
    D_WRITEDATA = {4{32'hCAFE_F00D}};
    D_READ = 1'b1;
    D_WRITE = 1'b1;
    step();
    total++; if (MEM_WRITE !== 1'b1) begin bad++; $display("FAIL illegal.mem_write got=%b exp=1", MEM_WRITE); end
    total++; if (MEM_READ !== 1'b0) begin bad++; $display("FAIL illegal.mem_read got=%b exp=0", MEM_READ); end
    total++; if (MEM_WRITEDATA !== {4{32'hCAFE_F00D}}) begin bad++; $display("FAIL illegal.writedata got=%h", MEM_WRITEDATA); end
    wait_free(1'b1, n);
    D_READ = 1'b0;
    D_WRITE = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset_mid();
    int n;
    D_ADDR = 28'h0000060;
    D_READ = 1'b1;
    step();
    total++; if (MEM_READ !== 1'b1) begin bad++; $display("FAIL reset_mid.pre_read got=%b exp=1", MEM_READ); end
    step();
    RESET = 1'b1;
    #1;
    total++; if (MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0) begin bad++; $display("FAIL reset_mid.async_drop got read=%b write=%b exp 0 0", MEM_READ, MEM_WRITE); end
    total++; if (MEM_ADDR !== 28'h0) begin bad++; $display("FAIL reset_mid.addr got=%h exp=0", MEM_ADDR); end
    total++; if (D_BUSYWAIT !== 1'b1) begin bad++; $display("FAIL reset_mid.d_busywait got=%b exp=1", D_BUSYWAIT); end
    step();
    total++; if (MEM_READ !== 1'b0) begin bad++; $display("FAIL reset_mid.held got=%b exp=0", MEM_READ); end
    RESET = 1'b0;
    step();
    total++; if (MEM_READ !== 1'b1 || MEM_ADDR !== 28'h0000060) begin bad++; $display("FAIL reset_mid.regrant got read=%b addr=%h exp read=1 addr=0000060", MEM_READ, MEM_ADDR); end
    wait_free(1'b1, n);
    total++; if (n !== BUSY_SAMPLES) begin bad++; $display("FAIL reset_mid.busy got=%0d exp=%0d", n, BUSY_SAMPLES); end
    D_READ = 1'b0;
    step();
    step();
  endtask

  task automatic test_drop();
    int n;
    int done;
    I_ADDR = 28'h0000070;
    D_ADDR = 28'h0000080;
    I_READ = 1'b1;
    step();
    step();
    I_READ = 1'b0;
    D_READ = 1'b1;
    #1;
    total++; if (MEM_READ !== 1'b1 || MEM_ADDR !== 28'h0000070) begin bad++; $display("FAIL drop.hold got read=%b addr=%h exp read=1 addr=0000070", MEM_READ, MEM_ADDR); end
    total++; if (I_BUSYWAIT !== 1'b1) begin bad++; $display("FAIL drop.i_busywait got=%b exp=1", I_BUSYWAIT); end
    n = 0;
    done = 0;
    for (int k = 0; k < 40 && done == 0; k++) begin
      step();
      n++;
      total++; if (MEM_READ !== 1'b1 || MEM_ADDR !== 28'h0000070) begin bad++; $display("FAIL drop.wait%0d got read=%b addr=%h exp read=1 addr=0000070", k, MEM_READ, MEM_ADDR); end
      if (!MEM_BUSYWAIT) done = 1;
    end
    // Grant began two samples earlier; STALL-1 busy samples then one free
    total++; if (n !== BUSY_SAMPLES - 1) begin bad++; $display("FAIL drop.wait_cycles got=%0d exp=%0d", n, BUSY_SAMPLES - 1); end
    step();
    total++; if (MEM_READ !== 1'b0 || D_BUSYWAIT !== 1'b1) begin bad++; $display("FAIL drop.release got read=%b dbw=%b exp read=0 dbw=1", MEM_READ, D_BUSYWAIT); end
    step();
    step();
    total++; if (MEM_READ !== 1'b1 || MEM_ADDR !== 28'h0000080) begin bad++; $display("FAIL drop.d_grant got read=%b addr=%h exp read=1 addr=0000080", MEM_READ, MEM_ADDR); end
    wait_free(1'b1, n);
    D_READ = 1'b0;
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_i_only();
    test_d_write();
    test_tie_serve();
    test_tie_sequence();
    test_illegal();
    test_reset_mid();
    test_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single block-wide instruction/data main memory between the instruction cache (read-only) and the data cache (read/write).
- Sits between both cache miss/write-back ports and the memory model.
- Serialises one 128-bit block transaction at a time.
- Uses the same level-held request / BUSYWAIT handshake as the caches.

Parameters:
- ADDR_W, 28, block address width (word address [31:4]).
- DATA_W, 128, block data width (4 x 32-bit words).

Ports:
- CLK  in  1  clock; all state updates on negedge CLK.
- RESET  in  1  reset.
- I_READ  in  1  I-cache block read request, held until I_BUSYWAIT=0.
- I_ADDR  in  ADDR_W  I-cache block address.
- I_READDATA  out  DATA_W  block returned to I-cache.
- I_BUSYWAIT  out  1  I-side stall.
- D_READ  in  1  D-cache block read request.
- D_WRITE  in  1  D-cache block write-back request.
- D_ADDR  in  ADDR_W  D-cache block address.
- D_WRITEDATA  in  DATA_W  write-back block.
- D_READDATA  out  DATA_W  block returned to D-cache.
- D_BUSYWAIT  out  1  D-side stall.
- MEM_READ  out  1  memory read strobe.
- MEM_WRITE  out  1  memory write strobe.
- MEM_ADDR  out  ADDR_W  memory block address.
- MEM_WRITEDATA  out  DATA_W  memory write block.
- MEM_READDATA  in  DATA_W  memory read block.
- MEM_BUSYWAIT  in  1  memory stall; high combinationally while a read/write is in progress.

Behaviour:
- Reset: RESET is asynchronous, active-high. State goes to IDLE and the grant-history bit clears to 0. Effective immediately, including mid-transaction.
- Outputs are decoded from state, so during RESET: MEM_READ=0, MEM_WRITE=0, MEM_ADDR=0, MEM_WRITEDATA=0.
- I_BUSYWAIT/D_BUSYWAIT during RESET follow their request lines (1 if requesting, else 0).
- I_READDATA and D_READDATA are wired directly to MEM_READDATA in every state.
- States: IDLE, GRANT_I, GRANT_D, RELEASE.
- IDLE:
  - No memory strobes.
  - x_BUSYWAIT = x request (D request = D_READ|D_WRITE).
  - At negedge: if both sides request, apply the priority rule; otherwise grant the sole requester. No request: stay IDLE.
- GRANT_I:
  - MEM_READ=1, MEM_ADDR=I_ADDR.
  - I_BUSYWAIT=MEM_BUSYWAIT; D_BUSYWAIT = D request.
  - When MEM_BUSYWAIT=0 at a negedge, go to RELEASE.
- GRANT_D:
  - D_WRITE=1: MEM_WRITE=1, MEM_WRITEDATA=D_WRITEDATA.
  - Else: MEM_READ=1.
  - If D_READ and D_WRITE are both high (illegal), write wins.
  - MEM_ADDR=D_ADDR; D_BUSYWAIT=MEM_BUSYWAIT; I_BUSYWAIT = I_READ.
  - When MEM_BUSYWAIT=0 at a negedge, go to RELEASE.
- RELEASE:
  - One cycle with no memory strobes and both BUSYWAITs = their request lines.
  - Gives the memory a strobe gap and lets the finished requester drop its request. Then go to IDLE.
- Latency: request seen at negedge n gives the grant from negedge n. Completion is visible in the same cycle MEM_BUSYWAIT falls. Minimum back-to-back spacing is grant, RELEASE, IDLE.
- If the granted requester drops its request mid-grant, the arbiter holds the strobe/address already latched by that requester's signals and still waits for MEM_BUSYWAIT=0. Memory transactions are never aborted.
- Request changes from the non-granted side are ignored until IDLE.
- No transaction is ever split or interleaved.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: round-robin on simultaneous requests. The side not granted last wins. The history bit updates on every grant.
- Undefined: fixed priority, D-side wins every tie (I-side can starve only while D requests back-to-back). The history bit is not synthesised.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding localparams (IDLE=2'b00, GRANT_I=2'b01, GRANT_D=2'b10, RELEASE=2'b11)
  - ADDR_W/DATA_W defaults
  - grant-select constants
- One natural sub-module: mem_arb_pick. Combinational tie-break (inputs: I request, D request, history; output: grant-D). Keeps the MEM_ARB_RR_EN ifdef local.

Test Plan:
- I-only: I_READ=1, I_ADDR=28'h0000010, memory 5-cycle stall returning 128'hA...A -> MEM_READ=1 with MEM_ADDR=28'h0000010; I_BUSYWAIT high until MEM_BUSYWAIT falls; I_READDATA=128'hA...A; then RELEASE, IDLE.
- D write-back: D_WRITE=1, D_ADDR=28'h0000020, D_WRITEDATA=128'h1234... -> MEM_WRITE=1, MEM_READ=0, data forwarded unchanged, D_BUSYWAIT mirrors MEM_BUSYWAIT.
- Tie: I_READ and D_READ rise on the same negedge.
  - Without the macro: GRANT_D first, I_BUSYWAIT=1 throughout, then GRANT_I after RELEASE/IDLE.
  - With MEM_ARB_RR_EN: three consecutive ties grant D, I, D.
- Illegal D_READ=D_WRITE=1 -> MEM_WRITE=1, MEM_READ=0.
- Reset mid GRANT_D: RESET pulse while MEM_BUSYWAIT=1 -> MEM_READ/MEM_WRITE drop to 0 asynchronously, state IDLE, the next request is granted normally.
- Requester drop: I_READ deasserted mid GRANT_I -> state holds until MEM_BUSYWAIT=0, then RELEASE; no D grant issued earlier.
